// File: rtl/fetch_queue_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_queue_pkg
// Purpose  : Shared constants, entry type and pointer-width helper for the queue.
// Revision : 1.0
//------------------------------------------------------------------------------
package fetch_queue_pkg;

   localparam int          FQ_DEPTH_DEFAULT = 4;
   localparam logic [31:0] FQ_NOP_INSTR     = 32'h0000_0000;
   localparam logic [31:0] FQ_PC_RESET      = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

   // A single-entry queue still needs one pointer bit.
   function automatic int fq_ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_queue_if
// Purpose  : Fetch-side push, decode-side pop, flush and occupancy signals.
// Revision : 1.0
//------------------------------------------------------------------------------
interface fetch_queue_if #(
   parameter int DEPTH = fetch_queue_pkg::FQ_DEPTH_DEFAULT
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic [31:0]      in_pc;
   logic [31:0]      in_instr;
   logic             in_ready;
   logic             out_valid;
   logic [31:0]      out_pc;
   logic [31:0]      out_instr;
   logic             out_ready;
   logic             flush;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_pc, in_instr, out_ready, flush,
      input  in_ready, out_valid, out_pc, out_instr, count
   );

   modport slave (
      input  in_valid, in_pc, in_instr, out_ready, flush,
      output in_ready, out_valid, out_pc, out_instr, count
   );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_storage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fq_storage
// Purpose  : DEPTH x 64-bit entry array, one write port, one async read port.
// Revision : 1.0
//------------------------------------------------------------------------------
module fq_storage
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH_DEFAULT,
   parameter int PTR_W = fq_ptr_width(DEPTH)
) (
   input  wire logic             clk,
   input  wire logic             we_i,
   input  wire logic [PTR_W-1:0] waddr_i,
   input  wire fq_entry_t        wdata_i,
   input  wire logic [PTR_W-1:0] raddr_i,
   output      fq_entry_t        rdata_o
);

   fq_entry_t mem_q [DEPTH];

   // No reset: validity is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_queue
// Purpose  : FIFO of {pc, instr} between fetch and decode with flush redirect.
// Revision : 1.0
//------------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int          DEPTH     = FQ_DEPTH_DEFAULT,
   parameter logic [31:0] NOP_INSTR = FQ_NOP_INSTR
) (
   input wire logic        clk,
   input wire logic        reset,
   fetch_queue_if.slave    q
);

   localparam int PTR_W = fq_ptr_width(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic      w_in_ready;
   logic      w_out_valid;
   logic      w_push;
   logic      w_pop;
   fq_entry_t w_wdata;
   fq_entry_t w_rdata;

   // Handshake qualifiers depend only on count_q, never on out_ready.
   assign w_in_ready  = (count_q < CNT_W'(DEPTH));
   assign w_out_valid = (count_q != '0);
   assign w_push      = q.in_valid && w_in_ready && !q.flush;
   assign w_pop       = w_out_valid && q.out_ready && !q.flush;
   assign w_wdata     = '{pc: q.in_pc, instr: q.in_instr};

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
      count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
      if (q.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fq_storage #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_storage (
      .clk     (clk),
      .we_i    (w_push),
      .waddr_i (wr_ptr_q),
      .wdata_i (w_wdata),
      .raddr_i (rd_ptr_q),
      .rdata_o (w_rdata)
   );

   assign q.in_ready  = w_in_ready;
   assign q.out_valid = w_out_valid;
   assign q.out_pc    = w_out_valid ? w_rdata.pc    : 32'h0000_0000;
   assign q.out_instr = w_out_valid ? w_rdata.instr : NOP_INSTR;
   assign q.count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fetch_queue
// Purpose  : Directed self-checking bench for fetch_queue (DEPTH=4).
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam logic [31:0] NOP = 32'hDEAD_0013;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   fetch_queue_if #(.DEPTH(4)) fq_if ();

   fetch_queue #(
      .DEPTH     (4),
      .NOP_INSTR (NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .q     (fq_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[15:0], 16'h0093};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fq_if.in_valid  = 1'b0;
      fq_if.in_pc     = 32'h0;
      fq_if.in_instr  = 32'h0;
      fq_if.out_ready = 1'b0;
      fq_if.flush     = 1'b0;
   endtask

   task automatic offer(input logic [31:0] pc);
      fq_if.in_valid = 1'b1;
      fq_if.in_pc    = pc;
      fq_if.in_instr = instr_of(pc);
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (fq_if.count !== 3'd0) begin
         errors++; $display("FAIL reset_count: got %0d expected 0", fq_if.count);
      end
      checks++;
      if (fq_if.in_ready !== 1'b1 || fq_if.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_hs: got in_ready=%b out_valid=%b expected 1/0", fq_if.in_ready, fq_if.out_valid);
      end
      checks++;
      if (fq_if.out_pc !== 32'h0 || fq_if.out_instr !== NOP) begin
         errors++; $display("FAIL reset_out: got pc=%h instr=%h expected 0/%h", fq_if.out_pc, fq_if.out_instr, NOP);
      end
   endtask

   task automatic test_fill3();
      do_reset();
      offer(FQ_PC_RESET);
      tick();
      checks++;
      if (fq_if.out_valid !== 1'b1 || fq_if.out_pc !== 32'h3000) begin
         errors++; $display("FAIL fill3_latency: got valid=%b pc=%h expected 1/3000", fq_if.out_valid, fq_if.out_pc);
      end
      offer(32'h3004); tick();
      offer(32'h3008); tick();
      idle_inputs();
      checks++;
      if (fq_if.count !== 3'd3) begin
         errors++; $display("FAIL fill3_count: got %0d expected 3", fq_if.count);
      end
      checks++;
      if (fq_if.out_pc !== 32'h3000 || fq_if.out_instr !== 32'h3000_0093) begin
         errors++; $display("FAIL fill3_head: got pc=%h instr=%h expected 3000/30000093", fq_if.out_pc, fq_if.out_instr);
      end
   endtask

   task automatic test_full();
      logic [31:0] exp_pc;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         offer(32'h3000 + 32'(4 * i));
         tick();
      end
      offer(32'h3010);
      checks++;
      if (fq_if.in_ready !== 1'b0 || fq_if.count !== 3'd4) begin
         errors++; $display("FAIL full_state: got in_ready=%b count=%0d expected 0/4", fq_if.in_ready, fq_if.count);
      end
      tick();
      checks++;
      if (fq_if.count !== 3'd4 || fq_if.out_pc !== 32'h3000) begin
         errors++; $display("FAIL full_hold: got count=%0d pc=%h expected 4/3000", fq_if.count, fq_if.out_pc);
      end
      // Pop while full: the held 3010 must not slip in on the same edge.
      fq_if.out_ready = 1'b1;
      tick();
      fq_if.out_ready = 1'b0;
      checks++;
      if (fq_if.count !== 3'd3 || fq_if.in_ready !== 1'b1 || fq_if.out_pc !== 32'h3004) begin
         errors++; $display("FAIL full_pop: got count=%0d in_ready=%b pc=%h expected 3/1/3004", fq_if.count, fq_if.in_ready, fq_if.out_pc);
      end
      tick();
      fq_if.in_valid = 1'b0;
      checks++;
      if (fq_if.count !== 3'd4) begin
         errors++; $display("FAIL full_accept: got count=%0d expected 4", fq_if.count);
      end
      fq_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'h3004 + 32'(4 * i);
         checks++;
         if (fq_if.out_pc !== exp_pc || fq_if.out_instr !== instr_of(exp_pc)) begin
            errors++; $display("FAIL full_drain[%0d]: got pc=%h instr=%h expected %h/%h", i, fq_if.out_pc, fq_if.out_instr, exp_pc, instr_of(exp_pc));
         end
         tick();
      end
      fq_if.out_ready = 1'b0;
      checks++;
      if (fq_if.count !== 3'd0 || fq_if.out_valid !== 1'b0 || fq_if.out_instr !== NOP) begin
         errors++; $display("FAIL full_empty: got count=%0d valid=%b instr=%h expected 0/0/%h", fq_if.count, fq_if.out_valid, fq_if.out_instr, NOP);
      end
      // Popping an empty queue must have no effect.
      fq_if.out_ready = 1'b1;
      tick();
      fq_if.out_ready = 1'b0;
      checks++;
      if (fq_if.count !== 3'd0) begin
         errors++; $display("FAIL empty_pop: got count=%0d expected 0", fq_if.count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc;
      do_reset();
      offer(32'h3000); tick();
      offer(32'h3004); tick();
      fq_if.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_pc = 32'h3000 + 32'(4 * i);
         offer(32'h3008 + 32'(4 * i));
         checks++;
         if (fq_if.out_pc !== exp_pc) begin
            errors++; $display("FAIL b2b_order[%0d]: got pc=%h expected %h", i, fq_if.out_pc, exp_pc);
         end
         tick();
         checks++;
         if (fq_if.count !== 3'd2) begin
            errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, fq_if.count);
         end
      end
      fq_if.in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_pc = 32'h3018 + 32'(4 * i);
         checks++;
         if (fq_if.out_pc !== exp_pc) begin
            errors++; $display("FAIL b2b_tail[%0d]: got pc=%h expected %h", i, fq_if.out_pc, exp_pc);
         end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         offer(32'h3000 + 32'(4 * i));
         tick();
      end
      offer(32'h4000);
      fq_if.out_ready = 1'b1;
      fq_if.flush     = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (fq_if.count !== 3'd0 || fq_if.out_valid !== 1'b0) begin
         errors++; $display("FAIL flush_state: got count=%0d valid=%b expected 0/0", fq_if.count, fq_if.out_valid);
      end
      checks++;
      if (fq_if.out_instr !== NOP || fq_if.out_pc !== 32'h0 || fq_if.in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_out: got pc=%h instr=%h in_ready=%b expected 0/%h/1", fq_if.out_pc, fq_if.out_instr, fq_if.in_ready, NOP);
      end
      tick();
      checks++;
      if (fq_if.count !== 3'd0) begin
         errors++; $display("FAIL flush_drop: got count=%0d expected 0", fq_if.count);
      end
      offer(32'h3020); tick();
      idle_inputs();
      checks++;
      if (fq_if.count !== 3'd1 || fq_if.out_pc !== 32'h3020) begin
         errors++; $display("FAIL flush_after: got count=%0d pc=%h expected 1/3020", fq_if.count, fq_if.out_pc);
      end
   endtask

   task automatic test_reset_full();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         offer(32'h3000 + 32'(4 * i));
         tick();
      end
      offer(32'h5000);
      fq_if.out_ready = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      checks++;
      if (fq_if.count !== 3'd0 || fq_if.in_ready !== 1'b1 || fq_if.out_valid !== 1'b0) begin
         errors++; $display("FAIL rstfull_state: got count=%0d in_ready=%b valid=%b expected 0/1/0", fq_if.count, fq_if.in_ready, fq_if.out_valid);
      end
      offer(FQ_PC_RESET); tick();
      idle_inputs();
      checks++;
      if (fq_if.count !== 3'd1 || fq_if.out_pc !== 32'h3000 || fq_if.out_instr !== 32'h3000_0093) begin
         errors++; $display("FAIL rstfull_push: got count=%0d pc=%h instr=%h expected 1/3000/30000093", fq_if.count, fq_if.out_pc, fq_if.out_instr);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         offer(32'h3000 + 32'(4 * i));
         tick();
      end
      // Seven simultaneous push/pop cycles, then drain: ten entries total.
      fq_if.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_pc = 32'h3000 + 32'(4 * i);
         if (i < 7) offer(32'h300C + 32'(4 * i));
         else       fq_if.in_valid = 1'b0;
         checks++;
         if (fq_if.out_valid !== 1'b1 || fq_if.out_pc !== exp_pc || fq_if.out_instr !== instr_of(exp_pc)) begin
            errors++; $display("FAIL wrap_order[%0d]: got valid=%b pc=%h instr=%h expected 1/%h/%h", i, fq_if.out_valid, fq_if.out_pc, fq_if.out_instr, exp_pc, instr_of(exp_pc));
         end
         tick();
      end
      idle_inputs();
      checks++;
      if (fq_if.count !== 3'd0 || fq_if.out_valid !== 1'b0) begin
         errors++; $display("FAIL wrap_empty: got count=%0d valid=%b expected 0/0", fq_if.count, fq_if.out_valid);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      idle_inputs();
      tick();
      test_reset();
      test_fill3();
      test_full();
      test_back_to_back();
      test_flush();
      test_reset_full();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
